// File: rtl/alu_opb_fwd_stage.sv
// alu_opb_fwd_stage
//   Registered ALU operand-B stage at the ID/EX boundary of the pipelined core.
//   Operand B comes from one of four sources: the rs2 register-file read data,
//   the sign-extended immediate, the EX/MEM forwarded result or the MEM/WB
//   forwarded result. The chosen value is captured into a valid/ready
//   pipeline register that supports stall and flush.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   Ars2, Bimext    : rs2 read data and sign-extended immediate
//   MUXopb          : 1 = immediate, 0 = register path (forwarding allowed)
//   rs2_addr        : rs2 index of the instruction in ID
//   exmem_*         : EX/MEM result, destination and write enable
//   memwb_*         : MEM/WB result, destination and write enable
//   in_valid/in_ready   : upstream handshake
//   flush           : kill stage contents (branch/jump redirect)
//   out_valid/out_ready : downstream handshake
//   outMuxb, out_src    : registered operand and its source code
//   fwd_count       : saturating count of accepted forwarded operands

module alu_opb_fwd_stage #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   Ars2,
  input  logic [WIDTH-1:0]   Bimext,
  input  logic               MUXopb,
  input  logic [RADDR_W-1:0] rs2_addr,
  input  logic [WIDTH-1:0]   exmem_result,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic               exmem_regwrite,
  input  logic [WIDTH-1:0]   memwb_result,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic               memwb_regwrite,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   outMuxb,
  output logic [1:0]         out_src,
  output logic [CNT_W-1:0]   fwd_count
);

  typedef enum logic [1:0] {
    SRC_RS2   = 2'b00,
    SRC_IMM   = 2'b01,
    SRC_EXMEM = 2'b10,
    SRC_MEMWB = 2'b11
  } src_e;

  logic             exmem_hit;
  logic             memwb_hit;
  logic [WIDTH-1:0] sel_data;
  src_e             sel_src;
  src_e             src_q;
  logic             take;

  // x0 is hardwired to zero, so a write to it never forwards.
  assign exmem_hit = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs2_addr);
  assign memwb_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs2_addr);

  // Youngest producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    sel_data = Ars2;
    sel_src  = SRC_RS2;
    if (MUXopb) begin
      sel_data = Bimext;
      sel_src  = SRC_IMM;
    end else if (exmem_hit) begin
      sel_data = exmem_result;
      sel_src  = SRC_EXMEM;
    end else if (memwb_hit) begin
      sel_data = memwb_result;
      sel_src  = SRC_MEMWB;
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready && !flush;
  assign out_src  = src_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      outMuxb   <= '0;
      src_q     <= SRC_RS2;
      fwd_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        outMuxb <= sel_data;
        src_q   <= sel_src;
      end
      // sel_src[1] marks either forwarding source.
      if (take && sel_src[1] && (fwd_count != '1))
        fwd_count <= fwd_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_opb_fwd_stage.sv
module tb_alu_opb_fwd_stage;

  localparam int WIDTH   = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   Ars2, Bimext, exmem_result, memwb_result;
  logic               MUXopb;
  logic [RADDR_W-1:0] rs2_addr, exmem_rd, memwb_rd;
  logic               exmem_regwrite, memwb_regwrite;
  logic               in_valid, in_ready, flush, out_valid, out_ready;
  logic [WIDTH-1:0]   outMuxb;
  logic [1:0]         out_src;
  logic [CNT_W-1:0]   fwd_count;

  always #5 clk = ~clk;

  alu_opb_fwd_stage #(.WIDTH(WIDTH), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Ars2(Ars2), .Bimext(Bimext), .MUXopb(MUXopb),
    .rs2_addr(rs2_addr), .exmem_result(exmem_result), .exmem_rd(exmem_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_result(memwb_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .outMuxb(outMuxb),
    .out_src(out_src), .fwd_count(fwd_count)
  );

  typedef struct {
    logic             muxopb;
    logic [WIDTH-1:0] ars2;
    logic [WIDTH-1:0] bimext;
    logic [4:0]       rs2;
    logic [WIDTH-1:0] exr;
    logic [4:0]       exrd;
    logic             exw;
    logic [WIDTH-1:0] wbr;
    logic [4:0]       wbrd;
    logic             wbw;
    logic [WIDTH-1:0] exp_d;
    logic [1:0]       exp_s;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   exp_cnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    MUXopb = v.muxopb; Ars2 = v.ars2; Bimext = v.bimext; rs2_addr = v.rs2;
    exmem_result = v.exr; exmem_rd = v.exrd; exmem_regwrite = v.exw;
    memwb_result = v.wbr; memwb_rd = v.wbrd; memwb_regwrite = v.wbw;
  endtask

  // Push the expected capture; bump the counter model for accepted forwards.
  task automatic push(input logic [WIDTH-1:0] d, input logic [1:0] s);
    exp_t e;
    e.d = d; e.s = s;
    sb.push_back(e);
    if (s[1] && exp_cnt < 15) exp_cnt++;
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    if (sb.size() == 0) begin
      tot_cnt++;
      $display("FAIL %s: scoreboard empty, got data %0h", nm, outMuxb);
    end else begin
      e = sb.pop_front();
      chk({nm, "_data"}, 64'(outMuxb), 64'(e.d));
      chk({nm, "_src"}, 64'(out_src), 64'(e.s));
    end
    chk({nm, "_cnt"}, 64'(fwd_count), 64'(exp_cnt));
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    // muxopb ars2 bimext rs2 exr exrd exw wbr wbrd wbw exp_d exp_s
    vecs[0] = '{1'b1, 32'h1111, 32'hFFFF_FFF0, 5'd5, 32'hAAAA, 5'd5, 1'b1, 32'hBBBB, 5'd5, 1'b1, 32'hFFFF_FFF0, 2'b01};
    vecs[1] = '{1'b0, 32'h1234, 32'h0, 5'd3, 32'hAAAA, 5'd4, 1'b1, 32'hBBBB, 5'd6, 1'b1, 32'h1234, 2'b00};
    vecs[2] = '{1'b0, 32'h1234, 32'h0, 5'd5, 32'hAAAA, 5'd5, 1'b1, 32'hBBBB, 5'd5, 1'b1, 32'hAAAA, 2'b10};
    vecs[3] = '{1'b0, 32'h1234, 32'h0, 5'd5, 32'hAAAA, 5'd5, 1'b0, 32'hBBBB, 5'd5, 1'b1, 32'hBBBB, 2'b11};
    vecs[4] = '{1'b0, 32'hCAFE, 32'h0, 5'd0, 32'hAAAA, 5'd0, 1'b1, 32'hBBBB, 5'd0, 1'b1, 32'hCAFE, 2'b00};
    vecs[5] = '{1'b0, 32'hBEEF, 32'h0, 5'd9, 32'hAAAA, 5'd8, 1'b1, 32'hBBBB, 5'd9, 1'b0, 32'hBEEF, 2'b00};

    v = vecs[1];
    drive(v);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step; step;
    rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(outMuxb), 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    chk("rst_cnt", 64'(fwd_count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Table vectors, back to back
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      push(vecs[i].exp_d, vecs[i].exp_s);
      step;
      pop_check($sformatf("vec%0d", i));
    end

    // Stall: capture 0x55, then hold while the source changes to 0x66
    v = vecs[1]; v.ars2 = 32'h55;
    drive(v);
    push(32'h55, 2'b00);
    step;
    pop_check("stall_cap");
    Ars2 = 32'h66;
    out_ready = 1'b0;
    #1;
    chk("stall_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("stall%0d_data", i), 64'(outMuxb), 64'h55);
      chk($sformatf("stall%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_ready", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    push(32'h66, 2'b00);
    step;
    pop_check("stall_release");

    // Flush with a valid forwarding input: dropped, data and count hold
    v = vecs[2]; v.rs2 = 5'd7; v.exrd = 5'd7; v.exr = 32'h999;
    drive(v);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_data", 64'(outMuxb), 64'h66);
    chk("flush_src", 64'(out_src), 64'd0);
    chk("flush_cnt", 64'(fwd_count), 64'(exp_cnt));

    // Empty: ready with no valid input clears out_valid, data holds
    v = vecs[1]; v.ars2 = 32'h77;
    drive(v);
    push(32'h77, 2'b00);
    step;
    pop_check("empty_cap");
    in_valid = 1'b0;
    Ars2 = 32'h88;
    step;
    chk("empty_valid", 64'(out_valid), 64'd0);
    chk("empty_data", 64'(outMuxb), 64'h77);

    // Counter saturation: 20 forwarded transfers, alternating sources
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v = vecs[2 + (i % 2)];
      v.exr = 32'h1000 + 32'(i);
      v.wbr = 32'h2000 + 32'(i);
      drive(v);
      push((i % 2 == 0) ? v.exr : v.wbr, (i % 2 == 0) ? 2'b10 : 2'b11);
      step;
      pop_check($sformatf("sat%0d", i));
    end
    chk("sat_final", 64'(fwd_count), 64'd15);

    // Reset during stall wins over the hold
    out_ready = 1'b0;
    step;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    exp_cnt = 0;
    chk("rst_stall_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_data", 64'(outMuxb), 64'd0);
    chk("rst_stall_src", 64'(out_src), 64'd0);
    chk("rst_stall_cnt", 64'(fwd_count), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
